// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
// Timed Morse key generator. It takes one letter (element count and a
// dot/dash pattern) or one word-space request per handshake. It then drives a
// single key line with standard Morse timing, measured in programmable units
// of UNIT_CYCLES clocks.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; aborts any letter in progress
//   in_valid     producer has a letter or space request
//   in_ready     keyer is idle and accepts on this edge
//   in_space     request is a word space (sym_len/sym_bits ignored)
//   sym_len      element count minus one (0..3)
//   sym_bits     pattern, bit sym_len sent first, bit 0 last (1 = dash)
//   key_out      1 while a mark is keyed
//   is_dash      1 while the current mark is a dash
//   busy         1 whenever not idle
//   letter_done  one-cycle pulse in the last cycle of a letter or space
// -----------------------------------------------------------------------------
module morse_keyer #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_space,
  input  logic [1:0] sym_len,
  input  logic [3:0] sym_bits,
  output logic       key_out,
  output logic       is_dash,
  output logic       busy,
  output logic       letter_done
);

  // Cycle counter only has to hold UNIT_CYCLES-1; keep at least one bit.
  localparam int            CW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MARK     = 3'd1,
    S_GAP_EL   = 3'd2,
    S_GAP_LTR  = 3'd3,
    S_GAP_WORD = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cyc;
  logic [2:0]    r_unit;
  logic [1:0]    r_idx;
  logic [3:0]    r_bits;

  logic          w_accept;
  logic          w_cur_dash;
  logic          w_unit_end;
  logic          w_state_end;
  logic [2:0]    w_units;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_cur_dash = r_bits[r_idx];
  assign w_unit_end = (r_cyc == CYC_LAST);

  // Number of units the current state lasts.
  always_comb begin
    w_units = 3'd1;
    case (r_state)
      S_MARK:     w_units = w_cur_dash ? 3'd3 : 3'd1;
      S_GAP_EL:   w_units = 3'd1;
      S_GAP_LTR:  w_units = 3'd3;
      S_GAP_WORD: w_units = 3'd4;
      default:    w_units = 3'd1;
    endcase
  end

  // Last cycle of a timed state: final cycle of its final unit.
  assign w_state_end = w_unit_end && (r_unit == (w_units - 3'd1)) && (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = in_space ? S_GAP_WORD : S_MARK;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MARK: begin
        if (w_state_end) begin
          w_next = (r_idx != 2'd0) ? S_GAP_EL : S_GAP_LTR;
        end else begin
          w_next = S_MARK;
        end
      end
      S_GAP_EL: begin
        if (w_state_end) begin
          w_next = S_MARK;
        end else begin
          w_next = S_GAP_EL;
        end
      end
      S_GAP_LTR, S_GAP_WORD: begin
        if (w_state_end) begin
          w_next = S_IDLE;
        end else begin
          w_next = r_state;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Cycle and unit counters; both restart at every state boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc  <= '0;
      r_unit <= 3'd0;
    end else if ((r_state == S_IDLE) || w_state_end) begin
      r_cyc  <= '0;
      r_unit <= 3'd0;
    end else if (w_unit_end) begin
      r_cyc  <= '0;
      r_unit <= r_unit + 3'd1;
    end else begin
      r_cyc  <= r_cyc + CW'(1);
      r_unit <= r_unit;
    end
  end

  // Letter capture at the handshake and element index stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_bits <= 4'd0;
    end else if (w_accept && !in_space) begin
      r_idx  <= sym_len;
      r_bits <= sym_bits;
    end else if ((r_state == S_GAP_EL) && w_state_end) begin
      r_idx  <= r_idx - 2'd1;
      r_bits <= r_bits;
    end else begin
      r_idx  <= r_idx;
      r_bits <= r_bits;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready    = 1'b0;
    key_out     = 1'b0;
    is_dash     = 1'b0;
    busy        = 1'b1;
    letter_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_MARK: begin
        key_out = 1'b1;
        is_dash = w_cur_dash;
      end
      S_GAP_EL: begin
        key_out = 1'b0;
      end
      S_GAP_LTR, S_GAP_WORD: begin
        letter_done = w_state_end;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
// Self-checking bench for morse_keyer. It uses three instances at U=1, U=2 and
// U=4, which share the clock, reset and data inputs and have separate in_valid
// lines. Expected per-cycle waveforms come from a reference model that expands
// a letter into its mark/gap timeline.
// -----------------------------------------------------------------------------
module tb_morse_keyer;

  logic       clk;
  logic       rst_n;
  logic       in_space;
  logic [1:0] sym_len;
  logic [3:0] sym_bits;
  logic       v0, v1, v2;
  logic       rdy0, rdy1, rdy2;
  logic       key0, key1, key2;
  logic       dsh0, dsh1, dsh2;
  logic       bsy0, bsy1, bsy2;
  logic       dn0, dn1, dn2;

  logic [4:0] obs [3];
  bit         q_key [$];
  bit         q_dash [$];
  int         n_cmp;
  int         n_fail;

  morse_keyer #(.UNIT_CYCLES(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_space(in_space),
    .sym_len(sym_len), .sym_bits(sym_bits), .key_out(key0), .is_dash(dsh0),
    .busy(bsy0), .letter_done(dn0)
  );
  morse_keyer #(.UNIT_CYCLES(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_space(in_space),
    .sym_len(sym_len), .sym_bits(sym_bits), .key_out(key1), .is_dash(dsh1),
    .busy(bsy1), .letter_done(dn1)
  );
  morse_keyer #(.UNIT_CYCLES(4)) u_k4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_space(in_space),
    .sym_len(sym_len), .sym_bits(sym_bits), .key_out(key2), .is_dash(dsh2),
    .busy(bsy2), .letter_done(dn2)
  );

  // Observation vector per instance: {key_out, is_dash, busy, letter_done, in_ready}
  assign obs[0] = {key0, dsh0, bsy0, dn0, rdy0};
  assign obs[1] = {key1, dsh1, bsy1, dn1, rdy1};
  assign obs[2] = {key2, dsh2, bsy2, dn2, rdy2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int uval(input int sel);
    case (sel)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic set_valid(input int sel, input logic val);
    case (sel)
      0:       v0 = val;
      1:       v1 = val;
      default: v2 = val;
    endcase
  endtask

  // Reference timeline: one entry per cycle after acceptance.
  task automatic build(input int u, input bit sp, input int len, input logic [3:0] bits);
    q_key.delete();
    q_dash.delete();
    if (sp) begin
      repeat (4 * u) begin q_key.push_back(1'b0); q_dash.push_back(1'b0); end
    end else begin
      for (int e = len; e >= 0; e--) begin
        int mlen;
        mlen = bits[e] ? 3 * u : u;
        repeat (mlen) begin q_key.push_back(1'b1); q_dash.push_back(bits[e]); end
        if (e != 0) begin
          repeat (u) begin q_key.push_back(1'b0); q_dash.push_back(1'b0); end
        end
      end
      repeat (3 * u) begin q_key.push_back(1'b0); q_dash.push_back(1'b0); end
    end
  endtask

  task automatic check(input int sel, input logic [4:0] ev, input string tag, input int t);
    n_cmp++;
    assert (obs[sel] === ev) else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0d observed=%b expected=%b", tag, sel, t, obs[sel], ev);
    end
  endtask

  // Send one request to instance sel, starting from a negedge of an idle cycle.
  // junk: scramble data inputs and pulse in_valid while busy.
  // hold: leave in_valid high in the final cycle (back-to-back follow-up).
  task automatic send(input int sel, input bit sp, input logic [1:0] len,
                      input logic [3:0] bits, input bit junk, input bit hold);
    int         lat;
    logic [4:0] ev;
    build(uval(sel), sp, int'(len), bits);
    lat      = q_key.size();
    in_space = sp;
    sym_len  = len;
    sym_bits = bits;
    set_valid(sel, 1'b1);
    @(posedge clk);
    for (int t = 1; t <= lat; t++) begin
      @(negedge clk);
      if (t == lat) set_valid(sel, hold);
      else if (junk) set_valid(sel, 1'($urandom_range(0, 1)));
      else set_valid(sel, 1'b0);
      if (junk) begin
        in_space = 1'($urandom);
        sym_len  = 2'($urandom);
        sym_bits = 4'($urandom);
      end
      ev = {q_key[t-1], q_dash[t-1], 1'b1, (t == lat), 1'b0};
      check(sel, ev, sp ? "space" : "letter", t);
    end
    @(negedge clk);
    check(sel, 5'b00001, "idle_after", lat + 1);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_space = 1'b0;
    sym_len  = 2'd0;
    sym_bits = 4'd0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) check(s, 5'b00001, "reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check(s, 5'b00001, "post_reset", 0);

    // E and A at U=2, with busy-time in_valid pulses and input scrambling
    send(1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0);
    send(1, 1'b0, 2'd1, 4'b0001, 1'b1, 1'b0);
    // O then Z back-to-back at U=1 with in_valid held
    send(0, 1'b0, 2'd2, 4'b0111, 1'b0, 1'b1);
    send(0, 1'b0, 2'd3, 4'b1100, 1'b0, 1'b0);
    // Word space at U=4, data inputs toggled during the request
    send(2, 1'b1, 2'd3, 4'b1111, 1'b1, 1'b0);

    // Reset during the leading dash of B at U=2
    in_space = 1'b0;
    sym_len  = 2'd3;
    sym_bits = 4'b1000;
    set_valid(1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(1, 1'b0);
    check(1, 5'b11100, "b_dash", 1);
    @(negedge clk);
    check(1, 5'b11100, "b_dash", 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(1, 5'b00001, "rst_abort", 3);
    repeat (2) begin
      @(negedge clk);
      check(1, 5'b00001, "rst_hold", 0);
    end
    rst_n = 1'b1;
    send(1, 1'b0, 2'd3, 4'b1000, 1'b0, 1'b0);

    // Randomized requests across all three unit lengths
    for (int i = 0; i < 30; i++) begin
      int         sel;
      bit         sp;
      logic [1:0] len;
      logic [3:0] bits;
      sel  = $urandom_range(0, 2);
      sp   = ($urandom_range(0, 5) == 0);
      len  = 2'($urandom);
      bits = 4'($urandom);
      send(sel, sp, len, bits, 1'($urandom), 1'b0);
    end
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
